// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and op-decoding helpers for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MADDU = 3'b011;
  localparam logic [2:0] OP_MSUB  = 3'b100;
  localparam logic [2:0] OP_MSUBU = 3'b101;
  localparam logic [2:0] OP_DIV   = 3'b110;
  localparam logic [2:0] OP_DIVU  = 3'b111;

  // op_i[2:1] groups an op with its unsigned twin
  localparam logic [1:0] KIND_MUL  = 2'b00;
  localparam logic [1:0] KIND_MADD = 2'b01;
  localparam logic [1:0] KIND_MSUB = 2'b10;
  localparam logic [1:0] KIND_DIV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  function automatic logic is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2:1] == KIND_DIV;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned operands; the load cycle already performs step one.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             last_step_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [WIDTH:0]   trial;
  logic             fits;

  // One shift/trial-subtract step per cycle while steps remain
  always_comb begin
    src_rem = load_i ? '0 : rem_q;
    src_quo = load_i ? dividend_i : quo_q;
    src_dvs = load_i ? divisor_i : dvs_q;
    trial   = {src_rem, src_quo[WIDTH-1]};
    fits    = trial >= {1'b0, src_dvs};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = src_dvs;
    cnt_d   = cnt_q;
    if (load_i || (cnt_q != '0)) begin
      rem_d = fits ? WIDTH'(trial - {1'b0, src_dvs}) : WIDTH'(trial);
      quo_d = {src_quo[WIDTH-2:0], fits};
      cnt_d = load_i ? CW'(WIDTH - 1) : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_step_o = (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle multiply / multiply-accumulate / divide unit with busy/flush handshake.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   op1_i,
  input  logic [WIDTH-1:0]   op2_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div0_o
);

  localparam int unsigned DW  = 2 * WIDTH;
  localparam int unsigned MCW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;

  state_e           state_q, state_d;
  logic [MCW-1:0]   mcnt_q, mcnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DW-1:0]    result_q, result_d;
  logic             div0_q, div0_d;
  logic             lat_en, div_load;

  logic [1:0]       kind_q;
  logic [WIDTH-1:0] a_q, b_q, op1_q;
  logic             neg_q, dneg_q;
  logic [DW-1:0]    hilo_q;

  logic             sgn_in, op1_neg_in, op2_neg_in;
  logic [WIDTH-1:0] abs1_in, abs2_in;

  logic [WIDTH-1:0] src_a, src_b;
  logic             src_neg;
  logic [1:0]       src_kind;
  logic [DW-1:0]    src_hilo, prod, sprod, mul_res;

  logic [WIDTH-1:0] quo, rem, quo_f, rem_f;
  logic [DW-1:0]    div_res;
  logic             div_last;

  // Operand magnitudes and sign bookkeeping at the request port
  always_comb begin
    sgn_in     = is_signed(op_i);
    op1_neg_in = sgn_in & op1_i[WIDTH-1];
    op2_neg_in = sgn_in & op2_i[WIDTH-1];
    abs1_in    = op1_neg_in ? -op1_i : op1_i;
    abs2_in    = op2_neg_in ? -op2_i : op2_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op1_q  <= '0;
      neg_q  <= 1'b0;
      dneg_q <= 1'b0;
      hilo_q <= '0;
    end else if (lat_en) begin
      kind_q <= op_i[2:1];
      a_q    <= abs1_in;
      b_q    <= abs2_in;
      op1_q  <= op1_i;
      neg_q  <= op1_neg_in ^ op2_neg_in;
      dneg_q <= op1_neg_in;
      hilo_q <= hilo_i;
    end
  end

  // Port-side sources let a single-stage multiply finish in the issue cycle
  always_comb begin
    src_a    = (state_q == IDLE) ? abs1_in : a_q;
    src_b    = (state_q == IDLE) ? abs2_in : b_q;
    src_neg  = (state_q == IDLE) ? (op1_neg_in ^ op2_neg_in) : neg_q;
    src_kind = (state_q == IDLE) ? op_i[2:1] : kind_q;
    src_hilo = (state_q == IDLE) ? hilo_i : hilo_q;
    prod     = DW'(src_a) * DW'(src_b);
    sprod    = src_neg ? -prod : prod;
    case (src_kind)
      KIND_MADD: mul_res = src_hilo + sprod;
      KIND_MSUB: mul_res = src_hilo - sprod;
      default:   mul_res = sprod;
    endcase
  end

  muldiv_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (div_load),
    .dividend_i  (abs1_in),
    .divisor_i   (abs2_in),
    .quotient_o  (quo),
    .remainder_o (rem),
    .last_step_o (div_last)
  );

  // Zero divisor reports all-ones quotient and the raw dividend as remainder
  always_comb begin
    quo_f   = neg_q ? -quo : quo;
    rem_f   = dneg_q ? -rem : rem;
    div_res = (b_q == '0) ? {op1_q, {WIDTH{1'b1}}} : {rem_f, quo_f};
  end

  always_comb begin
    state_d  = state_q;
    mcnt_d   = mcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    div0_d   = div0_q;
    lat_en   = 1'b0;
    div_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          lat_en = 1'b1;
          if (is_div(op_i)) begin
            div_load = 1'b1;
            busy_d   = 1'b1;
            state_d  = DIV;
          end else if (MUL_LATENCY <= 1) begin
            done_d   = 1'b1;
            result_d = mul_res;
            div0_d   = 1'b0;
          end else begin
            busy_d  = 1'b1;
            mcnt_d  = MCW'(MUL_LATENCY > 1 ? MUL_LATENCY - 2 : 0);
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (flush_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (mcnt_q == '0) begin
          done_d   = 1'b1;
          result_d = mul_res;
          div0_d   = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          mcnt_d = mcnt_q - MCW'(1);
        end
      end
      DIV: begin
        if (flush_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (div_last) begin
          state_d = FIX;
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!flush_i) begin
          done_d   = 1'b1;
          result_d = div_res;
          div0_d   = (b_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      div0_q   <= div0_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign div0_o   = div0_q;

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised multi-cycle multiply/divide unit for the EX stage. Accepts one operation per start pulse and runs a pipelined multiplier or a radix-2 restoring divider. Returns a {HI, LO} result with a single-cycle done pulse. Adds multiply-accumulate, a busy/flush handshake and defined divide-by-zero behaviour.

## Interface
- WIDTH, 32: operand width; result is 2*WIDTH.
- MUL_LATENCY, 2: cycles from start to done for multiply ops; minimum 1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  operation request; sampled only when busy_o is low.
- op_i  in  3  operation code: 000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 MSUBU, 110 DIV, 111 DIVU.
- op1_i  in  WIDTH  multiplicand or dividend.
- op2_i  in  WIDTH  multiplier or divisor.
- hilo_i  in  2*WIDTH  accumulator for MADD/MSUB; sampled at start.
- flush_i  in  1  exception flush; cancels the operation in flight.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle pulse; result_o is valid in this cycle.
- result_o  out  2*WIDTH  {HI, LO}. Multiply gives the full product. Divide gives {remainder, quotient}.
- div0_o  out  1  set with done_o when the divisor is zero; held until the next done_o.

## Operation
- States are IDLE, MUL, DIV and FIX.
- IDLE: start_i=1 latches op_i, op1_i, op2_i and hilo_i.
  - Multiply ops go to MUL.
  - DIV and DIVU go to DIV with step counter = WIDTH.
- Signed ops (even op_i[0]=0 ops) take absolute values of the operands at latch time. Unsigned ops use the raw operands.
- MUL:
  - Multiplies the absolute values through MUL_LATENCY register stages, then negates the 2*WIDTH product if the operand signs differ (signed ops).
  - MADD adds the product to hilo_i; MSUB computes hilo_i minus the product. Both are modulo 2^(2*WIDTH).
  - The last stage registers result_o, pulses done_o and returns to IDLE.
- DIV:
  - Each cycle performs one restoring step: shift the partial remainder left, try subtracting the divisor, set the quotient bit, decrement the counter.
  - When the counter reaches 0, go to FIX.
- FIX (signed ops):
  - Quotient is negated if the signs differ.
  - Remainder is negated if the dividend is negative; the remainder takes the dividend's sign.
  - Registers result_o and div0_o, pulses done_o, returns to IDLE.
- Divide by zero:
  - Runs full latency.
  - Quotient = all ones; remainder = op1 unmodified; div0_o=1.
- Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, no flag.
- result_o and div0_o hold their values between done pulses.

## Timing
- Reset: state IDLE, busy_o=0, done_o=0, div0_o=0, result_o=0. rst overrides flush_i and start_i.
- Cycle 0 is the cycle in which start_i is accepted.
  - Multiply: done_o in cycle MUL_LATENCY.
  - Divide: done_o in cycle WIDTH+1 (33 for WIDTH=32).
- busy_o:
  - High from cycle 1 through the cycle before done_o.
  - Low in the done_o cycle, so a start_i in the done_o cycle is accepted (back-to-back issue).
- start_i while busy_o=1 is ignored. There is no queueing; the pipeline must stall.
- flush_i=1 in any non-IDLE cycle: return to IDLE at the next edge, no done_o, result_o and div0_o unchanged.
  - A flush_i in the cycle where done_o would fire suppresses that done_o.
- flush_i and start_i in the same cycle: flush wins and the start is dropped.
- Only one operation is in flight; the MUL stages never hold two ops.

## Structure
- muldiv_pkg holds:
  - the op_i encodings (OP_MULT through OP_DIVU);
  - the state enum (IDLE, MUL, DIV, FIX);
  - a helper function is_signed(op).
- Sub-module muldiv_div_core holds the WIDTH-cycle restoring divider: partial remainder, quotient shift register and step counter. Its ports are load/abs operands in and quotient/remainder/last_step out.
- Sign handling, accumulate, the FSM and the handshake live in muldiv_iter.

## Test plan
WIDTH=32, MUL_LATENCY=2.
- MULT 0xFFFFFFFE × 0x00000003 -> result 0xFFFFFFFF_FFFFFFFA, done_o in cycle 2, busy_o high only in cycle 1.
- MADDU with hilo 0x00000001_FFFFFFFF, 1 × 1 -> 0x00000002_00000000. MSUB with hilo 0, 2 × 3 -> 0xFFFFFFFF_FFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2 -> {0xFFFFFFFF, 0xFFFFFFFD}, done_o in cycle 33. DIVU 0xFFFFFFF9 / 2 -> {0x00000001, 0x7FFFFFFC}.
- DIVU 5 / 0 -> {0x00000005, 0xFFFFFFFF}, div0_o=1. Then DIV 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}, div0_o=0.
- DIV started and flush_i in cycle 10 -> busy_o low in cycle 11, no done_o, result_o retains the previous value. A start_i during cycles 1–32 of a second DIV is ignored.
- Back-to-back: MULT issued in the done_o cycle of a DIV is accepted -> its done_o follows 2 cycles later. rst asserted mid-DIV -> all outputs zero next cycle.
